// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM states, default frame
// width and clock-phase mode encodings.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;

    localparam logic CPHA_0 = 1'b0;
    localparam logic CPHA_1 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL,
        DONE
    } state_t;

    // States during which chip select is asserted and the half-period counter runs.
    function automatic logic frame_active(input state_t s);
        return (s == LEAD) || (s == XFER) || (s == TRAIL);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter and sclk generator; provides edge strobes one cycle
// ahead of the registered sclk transition so the datapath moves with the edge.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic toggle_en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb,
    output logic half_done
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;

    assign half_done = en && (cnt == CNT_W'(CLK_DIV - 1));
    assign rise_stb  = half_done && toggle_en && !sclk;
    assign fall_stb  = half_done && toggle_en && sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else begin
            cnt <= half_done ? '0 : cnt + 1'b1;
            if (rise_stb) begin
                sclk <= 1'b1;
            end else if (fall_stb) begin
                sclk <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI bus master, clock idles low, per-frame phase select. One DATA_WIDTH word
// is shifted out MSB first on mosi while the same number of bits is captured from miso.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] masterDataIN,
    output logic [DATA_WIDTH-1:0] masterDataOUT,
    input  logic                  start,
    input  logic                  cpha,
    output logic                  busy,
    output logic                  done,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs,
    output state_t                state
);

    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

    // Handshake: a frame is accepted on any rising edge where start=1 and state
    // is IDLE; busy then stays high through the done cycle and start is ignored.

    state_t                next_state;
    logic                  cpha_q;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [BIT_W-1:0]      bit_cnt;

    logic accept;
    logic clk_en;
    logic toggle_en;
    logic rise_stb;
    logic fall_stb;
    logic half_done;
    logic last_fall;
    logic sample_stb;
    logic shift_stb;
    logic frame_end;

    assign accept    = (state == IDLE) && start;
    assign clk_en    = frame_active(state);
    assign toggle_en = (state == LEAD) || (state == XFER);
    assign last_fall = fall_stb && (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign frame_end = (state == TRAIL) && half_done;

    // Phase 0 samples on rises and shifts on falls (the final fall has nothing left
    // to shift); phase 1 shifts on rises and samples on falls.
    assign sample_stb = (cpha_q == CPHA_1) ? fall_stb : rise_stb;
    assign shift_stb  = (cpha_q == CPHA_1) ? rise_stb : (fall_stb && !last_fall);

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign cs   = !frame_active(state);

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (reset),
        .en       (clk_en),
        .toggle_en(toggle_en),
        .sclk     (sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .half_done(half_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)     next_state = LEAD;
            LEAD:    if (half_done) next_state = XFER;
            XFER:    if (last_fall) next_state = TRAIL;
            TRAIL:   if (half_done) next_state = DONE;
            DONE:                   next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpha_q        <= CPHA_0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            bit_cnt       <= '0;
            mosi          <= 1'b0;
            masterDataOUT <= '0;
        end else if (accept) begin
            cpha_q   <= cpha;
            bit_cnt  <= '0;
            rx_shift <= '0;
            // Phase 0 presents the MSB as soon as cs drops, so it leaves the shifter now.
            if (cpha == CPHA_1) begin
                tx_shift <= masterDataIN;
                mosi     <= 1'b0;
            end else begin
                tx_shift <= masterDataIN << 1;
                mosi     <= masterDataIN[DATA_WIDTH-1];
            end
        end else begin
            if (shift_stb) begin
                mosi     <= tx_shift[DATA_WIDTH-1];
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
            if (sample_stb) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
            end
            if (fall_stb) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (frame_end) begin
                masterDataOUT <= rx_shift;
                mosi          <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a behavioural SPI slave answers on miso and
// records mosi; frame timing, data and control behaviour are checked inline.
module tb_spi_master;
    import spi_pkg::*;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic [7:0] dout;
    logic       start;
    logic       cpha;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs;
    state_t     state;

    int tests_run    = 0;
    int tests_failed = 0;

    // Slave model state
    logic       slave_cpha = 1'b0;
    logic [7:0] slave_word = 8'h00;
    logic [7:0] mosi_cap   = 8'h00;
    logic       sclk_prev  = 1'b0;
    int         rises      = 0;
    int         falls      = 0;

    spi_master #(
        .DATA_WIDTH(8),
        .CLK_DIV   (CLK_DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .masterDataIN (din),
        .masterDataOUT(dout),
        .start        (start),
        .cpha         (cpha),
        .busy         (busy),
        .done         (done),
        .sclk         (sclk),
        .mosi         (mosi),
        .miso         (miso),
        .cs           (cs),
        .state        (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cs) begin
            rises = 0;
            falls = 0;
        end else begin
            if (sclk && !sclk_prev) begin
                rises++;
                mosi_cap = {mosi_cap[6:0], mosi};
            end
            if (!sclk && sclk_prev) falls++;
        end
        sclk_prev = sclk;
    end

    always_comb begin
        miso = 1'b0;
        if (!cs) begin
            if (!slave_cpha) begin
                if (falls < 8) miso = slave_word[7-falls];
            end else if (rises >= 1 && rises <= 8) begin
                miso = slave_word[8-rises];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] word, input logic mode,
                             input logic [7:0] sword, input int extra_cyc,
                             input logic [7:0] word2, input logic [7:0] exp_tx,
                             input logic [7:0] exp_rx);
        int   n          = 0;
        int   cs_low     = 0;
        int   sclk_hi    = 0;
        int   first_rise = 0;
        int   done_cyc   = 0;
        int   done_cnt   = 0;
        int   stray      = 0;
        logic busy_at_done = 1'b0;
        logic busy_after   = 1'b1;
        @(negedge clk);
        din        = word;
        cpha       = mode;
        slave_cpha = mode;
        slave_word = sword;
        start      = 1'b1;
        while (n < 200 && !(done_cyc != 0 && n >= done_cyc + 1)) begin
            @(negedge clk);
            n++;
            start = (n == extra_cyc);
            if (n == extra_cyc) begin
                din  = word2;
                cpha = ~mode;
            end
            if (!cs) cs_low++;
            if (sclk) sclk_hi++;
            if (sclk && first_rise == 0) first_rise = n;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc     = n;
                    busy_at_done = busy;
                end
            end else if (done_cyc != 0 && n == done_cyc + 1) begin
                busy_after = busy;
            end
        end
        check({tag, ".done_cycle"}, done_cyc, 17 * CLK_DIV + 1);
        check({tag, ".cs_low_cycles"}, cs_low, 17 * CLK_DIV);
        check({tag, ".first_rise"}, first_rise, 1 + CLK_DIV);
        check({tag, ".sclk_high_cycles"}, sclk_hi, 8 * CLK_DIV);
        check({tag, ".busy_at_done"}, busy_at_done, 1);
        check({tag, ".busy_after_done"}, busy_after, 0);
        check({tag, ".mosi_bits"}, mosi_cap, exp_tx);
        check({tag, ".rx_word"}, dout, exp_rx);
        check({tag, ".mosi_idle"}, mosi, 0);
        repeat (5) begin
            @(negedge clk);
            if (!cs || done) stray++;
        end
        check({tag, ".done_pulses"}, done_cnt, 1);
        check({tag, ".no_extra_frame"}, stray, 0);
    endtask

    initial begin
        int   n;
        int   fall1;
        int   fall2;
        int   gap;
        int   dones;
        logic prev_cs;

        reset = 1'b0;
        start = 1'b0;
        din   = 8'h00;
        cpha  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.cs", cs, 1);
        check("rst.sclk", sclk, 0);
        check("rst.mosi", mosi, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.dout", dout, 0);
        check("rst.state", 32'(state), 32'(IDLE));
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle.cs", cs, 1);
        check("idle.busy", busy, 0);

        run_frame("cpha0", 8'hAD, 1'b0, 8'h5A, 0, 8'h00, 8'hAD, 8'h5A);
        run_frame("cpha1", 8'h69, 1'b1, 8'hC3, 0, 8'h00, 8'h69, 8'hC3);
        run_frame("restart", 8'h3A, 1'b0, 8'h96, 20, 8'hC5, 8'h3A, 8'h96);

        // Asynchronous reset in the middle of a frame
        @(negedge clk);
        din        = 8'hF0;
        cpha       = 1'b0;
        slave_cpha = 1'b0;
        slave_word = 8'hFF;
        start      = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("midrst.pre_cs", cs, 0);
        #2 reset = 1'b0;
        #1;
        check("midrst.cs", cs, 1);
        check("midrst.sclk", sclk, 0);
        check("midrst.busy", busy, 0);
        check("midrst.dout", dout, 0);
        check("midrst.mosi", mosi, 0);
        check("midrst.state", 32'(state), 32'(IDLE));
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) dones++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst.no_done", dones, 0);
        run_frame("postrst", 8'hAD, 1'b0, 8'h3C, 0, 8'h00, 8'hAD, 8'h3C);

        // start held high continuously
        @(negedge clk);
        din     = 8'h55;
        cpha    = 1'b0;
        start   = 1'b1;
        prev_cs = cs;
        n       = 0;
        fall1   = 0;
        fall2   = 0;
        gap     = 0;
        dones   = 0;
        while (n < 220) begin
            @(negedge clk);
            n++;
            if (n == 150) start = 1'b0;
            if (!cs && prev_cs) begin
                if (fall1 == 0) fall1 = n;
                else if (fall2 == 0) fall2 = n;
            end
            if (cs && fall1 != 0 && fall2 == 0) gap++;
            if (done) dones++;
            prev_cs = cs;
        end
        check("b2b.first_cs_fall", fall1, 1);
        check("b2b.frame_period", fall2 - fall1, 17 * CLK_DIV + 2);
        check("b2b.cs_high_gap", gap, 2);
        check("b2b.done_pulses", dones, 3);

        run_frame("loop_cpha0", 8'hAD, 1'b0, 8'h3C, 0, 8'h00, 8'hAD, 8'h3C);
        run_frame("loop_cpha1", 8'hAD, 1'b1, 8'h3C, 0, 8'h00, 8'hAD, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
